fwd_ctrl: RTL and testbench



---
 rtl/fwd_ctrl.sv | 112 +++++++++++
 tb/tb_fwd_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_ctrl.sv
// fwd_ctrl: EX operand forwarding selects and load-use stall for the 5-stage MIPS pipeline.
// Optional feature macro FWD_POSTWB_EN: forward from the post-WB hold register (select code 11).
module fwd_ctrl #(
  parameter int REG_W    = 5,
  parameter int ZERO_REG = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_is_load,
  input  logic             flush,
  output logic [1:0]       fa_sel,
  output logic [1:0]       fb_sel,
  output logic             stall,
  output logic             ex_bubble
);

  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  // Stage records: _p0 = ID/EX (E), _p1 = EX/MEM (M), _p2 = MEM/WB (W).
  // Beyond W the regfile already holds the value, so no later record is needed.
  logic             vld_p0;
  logic             wr_en_p0;
  logic             is_load_p0;
  logic [REG_W-1:0] wr_reg_p0;
  logic             prod_p0;
  logic             prod_p1;
  logic [REG_W-1:0] wr_reg_p1;

  logic rs_hit_e, rs_hit_m, rs_hit_w;
  logic rt_hit_e, rt_hit_m, rt_hit_w;
  logic issue;
  logic [1:0] fa_code, fb_code;

  function automatic logic [1:0] sel_code(input logic used, input logic hit_e,
                                          input logic hit_m, input logic hit_w);
    logic [1:0] code;
    code = 2'b00;
    if (used) begin
      if (hit_e)      code = 2'b01;
      else if (hit_m) code = 2'b10;
      else if (hit_w) code = 2'b11;
    end
    return code;
  endfunction

  assign prod_p0  = vld_p0 & wr_en_p0 & (wr_reg_p0 != ZERO_IDX);
  assign rs_hit_e = prod_p0 & (id_rs == wr_reg_p0);
  assign rt_hit_e = prod_p0 & (id_rt == wr_reg_p0);
  assign rs_hit_m = prod_p1 & (id_rs == wr_reg_p1);
  assign rt_hit_m = prod_p1 & (id_rt == wr_reg_p1);

`ifdef FWD_POSTWB_EN
  logic             prod_p2;
  logic [REG_W-1:0] wr_reg_p2;

  assign rs_hit_w = prod_p2 & (id_rs == wr_reg_p2);
  assign rt_hit_w = prod_p2 & (id_rt == wr_reg_p2);

  always_ff @(posedge clk) begin
    if (!rst_n) prod_p2 <= 1'b0;
    else        prod_p2 <= prod_p1;
  end

  always_ff @(posedge clk) begin
    wr_reg_p2 <= wr_reg_p1;
  end
`else
  // Without the hold register the regfile writes through, so a W match reads the regfile.
  assign rs_hit_w = 1'b0;
  assign rt_hit_w = 1'b0;
`endif

  // A load in EX cannot feed the very next instruction; flush suppresses the stall.
  assign stall   = id_valid & ~flush & is_load_p0 &
                   ((id_use_rs & rs_hit_e) | (id_use_rt & rt_hit_e));
  assign issue   = id_valid & ~flush & ~stall;
  assign fa_code = sel_code(id_use_rs, rs_hit_e, rs_hit_m, rs_hit_w);
  assign fb_code = sel_code(id_use_rt, rt_hit_e, rt_hit_m, rt_hit_w);

  // ID -> EX boundary (control), EX -> MEM record advance
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      prod_p1   <= 1'b0;
      fa_sel    <= 2'b00;
      fb_sel    <= 2'b00;
      ex_bubble <= 1'b0;
    end else begin
      vld_p0    <= issue;
      prod_p1   <= prod_p0;
      fa_sel    <= issue ? fa_code : 2'b00;
      fb_sel    <= issue ? fb_code : 2'b00;
      ex_bubble <= stall | flush;
    end
  end

  // Record payloads; only meaningful while the matching valid/producer bit is set
  always_ff @(posedge clk) begin
    wr_en_p0   <= id_wr_en;
    wr_reg_p0  <= id_wr_reg;
    is_load_p0 <= id_is_load;
    wr_reg_p1  <= wr_reg_p0;
  end

endmodule

// File: tb/tb_fwd_ctrl.sv
// Scoreboard bench for fwd_ctrl: a reference model of what occupied EX in recent cycles
// predicts stall each cycle and the registered selects/bubble one cycle later.
module tb_fwd_ctrl;
  localparam int REG_W = 5;
`ifdef FWD_POSTWB_EN
  localparam int FWD_DEPTH = 3;
`else
  localparam int FWD_DEPTH = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             id_valid;
  logic [REG_W-1:0] id_rs, id_rt, id_wr_reg;
  logic             id_use_rs, id_use_rt, id_wr_en, id_is_load, flush;
  logic [1:0]       fa_sel, fb_sel;
  logic             stall, ex_bubble;

  always #5 clk = ~clk;

  fwd_ctrl #(.REG_W(REG_W), .ZERO_REG(0)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .flush(flush),
    .fa_sel(fa_sel), .fb_sel(fb_sel), .stall(stall), .ex_bubble(ex_bubble)
  );

  typedef struct {
    logic       vld;
    logic       wr_en;
    logic [4:0] rd;
    logic       ld;
  } slot_t;

  typedef struct {
    logic       vld;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       wr_en;
    logic [4:0] rd;
    logic       ld;
    logic       fl;
  } instr_t;

  typedef struct {
    int         cyc;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       bub;
    logic       e_load;
  } reg_exp_t;

  typedef struct {
    int   cyc;
    logic st;
  } st_exp_t;

  slot_t    hist[$];  // contents of EX, most recent first
  reg_exp_t rq[$];
  st_exp_t  sq[$];
  int       cyc   = 0;
  int       n_chk = 0;
  int       n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0b required=%0b", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_prod(input slot_t s);
    return s.vld && s.wr_en && (s.rd != 5'd0);
  endfunction

  // Newest producer within forwarding reach wins; its distance is the select code.
  function automatic logic [1:0] exp_code(input logic used, input logic [4:0] src);
    if (!used) return 2'b00;
    for (int d = 0; d < FWD_DEPTH; d++)
      if (d < hist.size() && is_prod(hist[d]) && hist[d].rd == src) return 2'(d + 1);
    return 2'b00;
  endfunction

  function automatic logic exp_stall(input instr_t i);
    if (!i.vld || i.fl || hist.size() == 0) return 1'b0;
    if (!is_prod(hist[0]) || !hist[0].ld) return 1'b0;
    return (i.use_rs && i.rs == hist[0].rd) || (i.use_rt && i.rt == hist[0].rd);
  endfunction

  // ---------------- stimulus ----------------
  task automatic step(input instr_t i, input logic rst_v, output logic st);
    reg_exp_t r;
    st_exp_t  s;
    slot_t    nxt;
    id_valid   = i.vld;
    id_rs      = i.rs;
    id_rt      = i.rt;
    id_use_rs  = i.use_rs;
    id_use_rt  = i.use_rt;
    id_wr_en   = i.wr_en;
    id_wr_reg  = i.rd;
    id_is_load = i.ld;
    flush      = i.fl;
    rst_n      = rst_v;
    st = exp_stall(i);
    s.cyc = cyc;
    s.st  = st;
    sq.push_back(s);
    r.cyc    = cyc + 1;
    r.fa     = 2'b00;
    r.fb     = 2'b00;
    r.bub    = 1'b0;
    r.e_load = (hist.size() > 0) && is_prod(hist[0]) && hist[0].ld;
    nxt.vld = 1'b0; nxt.wr_en = 1'b0; nxt.rd = 5'd0; nxt.ld = 1'b0;
    if (!rst_v) begin
      hist.delete();
    end else if (!i.vld || i.fl || st) begin
      r.bub = st | i.fl;
      hist.push_front(nxt);
    end else begin
      r.fa = exp_code(i.use_rs, i.rs);
      r.fb = exp_code(i.use_rt, i.rt);
      nxt.vld = 1'b1; nxt.wr_en = i.wr_en; nxt.rd = i.rd; nxt.ld = i.ld;
      hist.push_front(nxt);
    end
    while (hist.size() > 4) void'(hist.pop_back());
    rq.push_back(r);
    @(posedge clk);
    #1;
  endtask

  // Re-presents a stalled instruction until it issues.
  task automatic issue(input instr_t i);
    logic st;
    for (int k = 0; k < 3; k++) begin
      step(i, 1'b1, st);
      if (!st) return;
    end
    n_chk++;
    n_fail++;
    $display("FAIL stall_bound cyc=%0d actual=still_stalled required=issued", cyc);
  endtask

  function automatic instr_t mk(input int rs, input int rt, input bit urs, input bit urt,
                                input bit we, input int rd, input bit ld, input bit fl);
    instr_t i;
    i.vld = 1'b1; i.rs = 5'(rs); i.rt = 5'(rt); i.use_rs = urs; i.use_rt = urt;
    i.wr_en = we; i.rd = 5'(rd); i.ld = ld; i.fl = fl;
    return i;
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i.vld    = ($urandom_range(0, 99) < 85);
    i.rs     = 5'($urandom_range(0, 7));
    i.rt     = 5'($urandom_range(0, 7));
    i.use_rs = 1'($urandom_range(0, 1));
    i.use_rt = 1'($urandom_range(0, 1));
    i.wr_en  = ($urandom_range(0, 9) < 8);
    i.rd     = 5'($urandom_range(0, 7));
    i.ld     = ($urandom_range(0, 9) < 3);
    i.fl     = ($urandom_range(0, 9) == 0);
    return i;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    st_exp_t  s;
    reg_exp_t r;
    if (sq.size() > 0 && sq[0].cyc == cyc) begin
      s = sq.pop_front();
      check("stall", {1'b0, stall}, {1'b0, s.st});
    end
    if (rq.size() > 0 && rq[0].cyc == cyc) begin
      r = rq.pop_front();
      check("fa_sel", fa_sel, r.fa);
      check("fb_sel", fb_sel, r.fb);
      check("ex_bubble", {1'b0, ex_bubble}, {1'b0, r.bub});
      if (fa_sel == 2'b01 || fb_sel == 2'b01)
        check("sel01_from_load", {1'b0, r.e_load}, 2'b00);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t nop, cur;
    logic   st;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
    nop.vld = 1'b0;
    rst_n = 1'b0;
    void'(rand_instr());
    cur = rand_instr();
    id_valid = cur.vld; id_rs = cur.rs; id_rt = cur.rt; id_use_rs = cur.use_rs;
    id_use_rt = cur.use_rt; id_wr_en = cur.wr_en; id_wr_reg = cur.rd;
    id_is_load = cur.ld; flush = 1'b0;
    @(posedge clk);
    #1;

    // reset held with random ID traffic
    step(rand_instr(), 1'b0, st);
    step(rand_instr(), 1'b0, st);

    // first independent instruction
    issue(mk(9, 10, 1, 1, 1, 1, 0, 0));

    // ALU chain on $3: EX/MEM, then MEM/WB, then post-WB (or regfile)
    issue(mk(11, 12, 1, 1, 1, 3, 0, 0));
    issue(mk(3, 13, 1, 1, 1, 6, 0, 0));
    issue(mk(14, 3, 1, 1, 1, 8, 0, 0));
    issue(mk(15, 3, 1, 1, 1, 9, 0, 0));

    // load-use: one stall, then MEM/WB forward
    issue(mk(16, 17, 1, 1, 1, 5, 1, 0));
    issue(mk(5, 18, 1, 1, 1, 10, 0, 0));

    // priority: newest writer of $7 wins; $0 never forwarded
    issue(mk(19, 20, 1, 1, 1, 7, 0, 0));
    issue(mk(21, 22, 1, 1, 1, 7, 0, 0));
    issue(mk(7, 23, 1, 1, 1, 11, 0, 0));
    issue(mk(24, 25, 1, 1, 1, 0, 0, 0));
    issue(mk(0, 0, 1, 1, 1, 12, 0, 0));

    // flush during a load-use hazard
    issue(mk(26, 27, 1, 1, 1, 4, 1, 0));
    issue(mk(4, 28, 1, 1, 1, 13, 0, 1));
    issue(mk(29, 30, 1, 1, 1, 14, 0, 0));

    // dual operand load-use
    issue(mk(27, 28, 1, 1, 1, 2, 1, 0));
    issue(mk(2, 2, 1, 1, 1, 15, 0, 0));

    // reset mid-operation discards producers
    issue(mk(16, 17, 1, 1, 1, 3, 1, 0));
    step(mk(3, 3, 1, 1, 1, 20, 0, 0), 1'b0, st);
    issue(mk(3, 3, 1, 1, 1, 21, 0, 0));
    step(nop, 1'b1, st);

    // randomized traffic on a small register set to force frequent hazards
    st = 1'b0;
    cur = rand_instr();
    for (int n = 0; n < 800; n++) begin
      if (!st) cur = rand_instr();
      else     cur.fl = ($urandom_range(0, 9) == 0);
      step(cur, ($urandom_range(0, 99) != 0), st);
    end
    step(nop, 1'b1, st);

    repeat (2) @(posedge clk);
    #1;
    while (sq.size() > 0) begin
      void'(sq.pop_front());
      n_chk++;
      n_fail++;
      $display("FAIL stall_unchecked cyc=%0d actual=pending required=consumed", cyc);
    end
    while (rq.size() > 0) begin
      void'(rq.pop_front());
      n_chk++;
      n_fail++;
      $display("FAIL sel_unchecked cyc=%0d actual=pending required=consumed", cyc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
